// File: rtl/jtoutrun_obj_scan.sv
// Per-line sprite table scanner: selects entries covering the render line and feeds them to the draw engine.
// Optional sprite-per-line cap enabled by defining JTOUTRUN_OBJ_SCAN_LIMIT_EN.
module jtoutrun_obj_scan (
  input  logic        rst,
  input  logic        clk,
  input  logic        hstart,
  input  logic [8:0]  vrender,
  output logic [9:0]  tbl_addr,
  input  logic [15:0] tbl_dout,
  output logic        dr_start,
  input  logic        dr_busy,
  output logic [8:0]  dr_xpos,
  output logic [15:0] dr_offset,
  output logic [2:0]  dr_bank,
  output logic [1:0]  dr_prio,
  output logic        dr_shadow,
  output logic [6:0]  dr_pal,
  output logic [4:0]  dr_hzoom,
  output logic        dr_hflip,
  output logic        dr_backwd,
  output logic        scan_busy
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RDATTR, ISSUE, WAIT, NEXT} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  entry_reg;
  logic [2:0]  word_reg;
  logic [8:0]  vline_reg;
  logic [8:0]  top_reg;
  logic [8:0]  line_reg;
  logic [15:0] base_reg;
  logic        guard_reg;
  logic        visible;
  logic        cap_hit;
  logic [15:0] prod_lo;

`ifdef JTOUTRUN_OBJ_SCAN_LIMIT_EN
  logic [5:0]  nstart_reg;
  assign cap_hit = (nstart_reg == 6'd32);
`else
  assign cap_hit = 1'b0;
`endif

  // RDATTR sub-step k issues word k+2 while word k+1 arrives on tbl_dout
  always_comb begin
    tbl_addr = {entry_reg, 3'd0};
    case (state_reg)
      RD1:     tbl_addr = {entry_reg, 3'd1};
      RDATTR:  tbl_addr = {entry_reg, word_reg + 3'd2};
      default: tbl_addr = {entry_reg, 3'd0};
    endcase
  end

  assign visible   = (top_reg <= vline_reg) && (vline_reg < tbl_dout[8:0]);
  assign prod_lo   = 16'($signed(tbl_dout) * $signed({1'b0, line_reg}));
  assign scan_busy = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    dr_start   = 1'b0;
    case (state_reg)
      IDLE:   state_next = IDLE;
      RD0:    state_next = RD1;
      RD1: begin
        if (tbl_dout[15])      state_next = IDLE;
        else if (tbl_dout[14]) state_next = NEXT;
        else                   state_next = RDATTR;
      end
      RDATTR: begin
        if (word_reg == 3'd0 && !visible) state_next = NEXT;
        else if (word_reg == 3'd4)        state_next = ISSUE;
      end
      ISSUE: begin
        if (!dr_busy) begin
          dr_start   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // busy from the engine lags the start pulse by a cycle
        if (!guard_reg && !dr_busy) state_next = cap_hit ? IDLE : NEXT;
      end
      NEXT:    state_next = (entry_reg == 7'd127) ? IDLE : RD0;
      default: state_next = IDLE;
    endcase
    if (hstart) begin
      state_next = RD0;
      dr_start   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      entry_reg <= 7'd0;
      word_reg  <= 3'd0;
      vline_reg <= 9'd0;
      top_reg   <= 9'd0;
      line_reg  <= 9'd0;
      base_reg  <= 16'd0;
      guard_reg <= 1'b0;
      dr_xpos   <= 9'd0;
      dr_offset <= 16'd0;
      dr_bank   <= 3'd0;
      dr_prio   <= 2'd0;
      dr_shadow <= 1'b0;
      dr_pal    <= 7'd0;
      dr_hzoom  <= 5'd0;
      dr_hflip  <= 1'b0;
      dr_backwd <= 1'b0;
`ifdef JTOUTRUN_OBJ_SCAN_LIMIT_EN
      nstart_reg <= 6'd0;
`endif
    end else begin
      state_reg <= state_next;
      guard_reg <= dr_start;
      word_reg  <= (state_reg == RDATTR) ? word_reg + 3'd1 : 3'd0;
      if (hstart) begin
        vline_reg <= vrender;
        entry_reg <= 7'd0;
      end else if (state_reg == NEXT) begin
        entry_reg <= entry_reg + 7'd1;
      end
      if (state_reg == RD1) top_reg <= tbl_dout[8:0];
      if (state_reg == RDATTR) begin
        case (word_reg)
          3'd0: line_reg <= vline_reg - top_reg;
          3'd1: begin
            dr_xpos   <= tbl_dout[8:0];
            dr_hflip  <= tbl_dout[9];
            dr_backwd <= tbl_dout[10];
            dr_shadow <= tbl_dout[11];
            dr_prio   <= tbl_dout[13:12];
          end
          3'd2: base_reg  <= tbl_dout;
          3'd3: dr_offset <= base_reg + prod_lo;
          3'd4: begin
            dr_pal   <= tbl_dout[6:0];
            dr_bank  <= tbl_dout[10:8];
            dr_hzoom <= tbl_dout[15:11];
          end
          default: ;
        endcase
      end
`ifdef JTOUTRUN_OBJ_SCAN_LIMIT_EN
      if (hstart)        nstart_reg <= 6'd0;
      else if (dr_start) nstart_reg <= nstart_reg + 6'd1;
`endif
    end
  end

endmodule

// File: tb/tb_jtoutrun_obj_scan.sv
// Directed bench for jtoutrun_obj_scan: table RAM model, draw-engine busy model, per-scenario checks.
module tb_jtoutrun_obj_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hstart = 1'b0;
  logic [8:0]  vrender = 9'd0;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        dr_start, dr_busy, dr_shadow, dr_hflip, dr_backwd, scan_busy;
  logic [8:0]  dr_xpos;
  logic [15:0] dr_offset;
  logic [2:0]  dr_bank;
  logic [1:0]  dr_prio;
  logic [6:0]  dr_pal;
  logic [4:0]  dr_hzoom;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtoutrun_obj_scan dut (
    .rst(rst), .clk(clk), .hstart(hstart), .vrender(vrender),
    .tbl_addr(tbl_addr), .tbl_dout(tbl_dout),
    .dr_start(dr_start), .dr_busy(dr_busy),
    .dr_xpos(dr_xpos), .dr_offset(dr_offset), .dr_bank(dr_bank),
    .dr_prio(dr_prio), .dr_shadow(dr_shadow), .dr_pal(dr_pal),
    .dr_hzoom(dr_hzoom), .dr_hflip(dr_hflip), .dr_backwd(dr_backwd),
    .scan_busy(scan_busy)
  );

  logic [15:0] mem [0:1023];
  always @(posedge clk) tbl_dout <= mem[tbl_addr];

  // draw engine: busy for busy_len cycles after each start, dropped by hstart
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (hstart)        busy_cnt <= 0;
    else if (dr_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign dr_busy = (busy_cnt != 0);

  int ncyc = 0, start_cnt = 0, viol = 0, hs_cyc = 0, busy_cyc = 0;
  int          st_cyc [0:63];
  logic [15:0] st_off [0:63];
  always @(negedge clk) begin
    ncyc++;
    if (hstart) hs_cyc = ncyc;
    if (scan_busy) busy_cyc++;
    if (dr_start) begin
      if (start_cnt < 64) begin
        st_cyc[start_cnt] = ncyc;
        st_off[start_cnt] = dr_offset;
      end
      start_cnt++;
      if (dr_busy) viol++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic set_entry(input int e, input logic [15:0] w0, w1, w2, w3, w4, w5);
    mem[e*8+0] = w0; mem[e*8+1] = w1; mem[e*8+2] = w2;
    mem[e*8+3] = w3; mem[e*8+4] = w4; mem[e*8+5] = w5;
  endtask

  task automatic pulse_hstart(input logic [8:0] v);
    @(posedge clk); #1;
    hstart = 1'b1; vrender = v;
    @(posedge clk); #1;
    hstart = 1'b0;
  endtask

  task automatic kick(input logic [8:0] v);
    start_cnt = 0; viol = 0; busy_cyc = 0;
    pulse_hstart(v);
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (!scan_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hstart = 1'b1; vrender = 9'd33;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tbl_addr !== 10'd0)  begin bad++; $display("FAIL reset_tbl_addr got=%h want=0", tbl_addr); end
    total++; if (dr_start !== 1'b0)   begin bad++; $display("FAIL reset_dr_start got=%b want=0", dr_start); end
    total++; if (scan_busy !== 1'b0)  begin bad++; $display("FAIL reset_scan_busy got=%b want=0", scan_busy); end
    total++; if (dr_offset !== 16'd0) begin bad++; $display("FAIL reset_dr_offset got=%h want=0", dr_offset); end
    total++; if ({dr_xpos, dr_bank, dr_prio, dr_shadow, dr_pal, dr_hzoom, dr_hflip, dr_backwd} !== 30'd0)
      begin bad++; $display("FAIL reset_attrs got=%h want=0", {dr_xpos, dr_bank, dr_prio, dr_shadow, dr_pal, dr_hzoom, dr_hflip, dr_backwd}); end
    rst = 1'b0; hstart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (scan_busy !== 1'b0) begin bad++; $display("FAIL reset_hstart_ignored scan_busy got=%b want=0", scan_busy); end
    $display("test_reset done");
  endtask

  task automatic test_visible();
    bit ok;
    clear_mem();
    busy_len = 0;
    set_entry(0, 16'd10, 16'd20, 16'h2B23, 16'h1000, 16'h0004, 16'h9D55);
    kick(9'd15);
    wait_idle(2000, ok);
    total++; if (!ok)              begin bad++; $display("FAIL visible_timeout scan_busy still high"); end
    total++; if (start_cnt !== 1)  begin bad++; $display("FAIL visible_starts got=%0d want=1", start_cnt); end
    total++; if (st_off[0] !== 16'h1014) begin bad++; $display("FAIL visible_offset got=%h want=1014", st_off[0]); end
    total++; if (st_cyc[0] - hs_cyc !== 8) begin bad++; $display("FAIL visible_latency got=%0d want=8", st_cyc[0] - hs_cyc); end
    total++; if (dr_xpos !== 9'h123) begin bad++; $display("FAIL visible_xpos got=%h want=123", dr_xpos); end
    total++; if ({dr_hflip, dr_backwd, dr_shadow} !== 3'b101) begin bad++; $display("FAIL visible_flags got=%b want=101", {dr_hflip, dr_backwd, dr_shadow}); end
    total++; if (dr_prio !== 2'd2)   begin bad++; $display("FAIL visible_prio got=%0d want=2", dr_prio); end
    total++; if (dr_pal !== 7'h55)   begin bad++; $display("FAIL visible_pal got=%h want=55", dr_pal); end
    total++; if (dr_bank !== 3'd5)   begin bad++; $display("FAIL visible_bank got=%0d want=5", dr_bank); end
    total++; if (dr_hzoom !== 5'h13) begin bad++; $display("FAIL visible_hzoom got=%h want=13", dr_hzoom); end
    total++; if (busy_cyc !== 519)   begin bad++; $display("FAIL visible_scan_len got=%0d want=519", busy_cyc); end
    $display("test_visible starts=%0d offset=%h", start_cnt, st_off[0]);
  endtask

  task automatic test_offline();
    bit ok;
    logic [8:0] lines [0:1];
    lines[0] = 9'd20; lines[1] = 9'd9;
    for (int k = 0; k < 2; k++) begin
      kick(lines[k]);
      wait_idle(2000, ok);
      total++; if (!ok || start_cnt !== 0) begin bad++; $display("FAIL offline_starts line=%0d got=%0d want=0 ok=%0d", lines[k], start_cnt, ok); end
      total++; if (busy_cyc !== 512) begin bad++; $display("FAIL offline_scan_len line=%0d got=%0d want=512", lines[k], busy_cyc); end
      $display("test_offline line=%0d starts=%0d busy=%0d", lines[k], start_cnt, busy_cyc);
    end
  endtask

  task automatic test_end_busy();
    bit ok;
    clear_mem();
    busy_len = 50;
    for (int i = 0; i < 3; i++)
      set_entry(i, 16'd0, 16'd100, 16'h0000, 16'(i * 256), 16'(i + 1), 16'h0000);
    set_entry(3, 16'h8000, 16'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    kick(9'd50);
    wait_idle(3000, ok);
    total++; if (!ok || start_cnt !== 3) begin bad++; $display("FAIL end_starts got=%0d want=3 ok=%0d", start_cnt, ok); end
    total++; if (viol !== 0) begin bad++; $display("FAIL end_start_while_busy got=%0d want=0", viol); end
    total++; if (st_cyc[1] - st_cyc[0] !== 60) begin bad++; $display("FAIL end_gap01 got=%0d want=60", st_cyc[1] - st_cyc[0]); end
    total++; if (st_cyc[2] - st_cyc[1] !== 60) begin bad++; $display("FAIL end_gap12 got=%0d want=60", st_cyc[2] - st_cyc[1]); end
    total++; if (st_off[0] !== 16'h0032) begin bad++; $display("FAIL end_off0 got=%h want=0032", st_off[0]); end
    total++; if (st_off[1] !== 16'h0164) begin bad++; $display("FAIL end_off1 got=%h want=0164", st_off[1]); end
    total++; if (st_off[2] !== 16'h0296) begin bad++; $display("FAIL end_off2 got=%h want=0296", st_off[2]); end
    $display("test_end_busy starts=%0d viol=%0d", start_cnt, viol);
  endtask

  task automatic test_wrap();
    bit ok;
    clear_mem();
    busy_len = 0;
    set_entry(0, 16'd10, 16'd20, 16'h0000, 16'h0001, 16'hFFFE, 16'h0000);
    kick(9'd11);
    wait_idle(2000, ok);
    total++; if (!ok || start_cnt !== 1) begin bad++; $display("FAIL wrap_starts got=%0d want=1", start_cnt); end
    total++; if (st_off[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_offset got=%h want=ffff", st_off[0]); end
    $display("test_wrap offset=%h", st_off[0]);
  endtask

  task automatic test_abort();
    bit ok;
    bit hit;
    clear_mem();
    busy_len = 20;
    for (int i = 0; i < 6; i++)
      set_entry(i, 16'd0, 16'd100, 16'h0000, 16'h0000, 16'h0001, 16'h0000);
    kick(9'd50);
    hit = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (start_cnt >= 6) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL abort_reach_entry5 starts=%0d want=6", start_cnt); end
    total++; if (tbl_addr[9:3] !== 7'd5) begin bad++; $display("FAIL abort_in_entry5 got=%0d want=5", tbl_addr[9:3]); end
    hstart = 1'b1; vrender = 9'd50;
    @(posedge clk); #1;
    hstart = 1'b0;
    total++; if (tbl_addr !== 10'd0) begin bad++; $display("FAIL abort_restart_addr got=%h want=0", tbl_addr); end
    repeat (7) @(negedge clk);
    total++; if (start_cnt !== 6) begin bad++; $display("FAIL abort_stray_start got=%0d want=6", start_cnt); end
    wait_idle(3000, ok);
    total++; if (!ok || start_cnt !== 12) begin bad++; $display("FAIL abort_total_starts got=%0d want=12", start_cnt); end
    total++; if (st_cyc[6] - hs_cyc !== 8) begin bad++; $display("FAIL abort_restart_latency got=%0d want=8", st_cyc[6] - hs_cyc); end
    total++; if (viol !== 0) begin bad++; $display("FAIL abort_start_while_busy got=%0d want=0", viol); end
    $display("test_abort starts=%0d", start_cnt);
  endtask

  task automatic test_many();
    bit ok;
    int want;
`ifdef JTOUTRUN_OBJ_SCAN_LIMIT_EN
    want = 32;
`else
    want = 40;
`endif
    clear_mem();
    busy_len = 0;
    for (int i = 0; i < 40; i++)
      set_entry(i, 16'd0, 16'd100, 16'h0000, 16'h0000, 16'h0001, 16'h0000);
    kick(9'd50);
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL many_timeout scan_busy still high"); end
    total++; if (start_cnt !== want) begin bad++; $display("FAIL many_starts got=%0d want=%0d", start_cnt, want); end
    $display("test_many starts=%0d", start_cnt);
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_visible();
    test_offline();
    test_end_busy();
    test_wrap();
    test_abort();
    test_many();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
